// File: rtl/button_sequence_controller.sv
// Generates an 8-slot random button sequence from a free-running LFSR, then scores player presses against it.
// Wrong presses pulse strike, clear progress and accumulate strikes; reaching MAX_STRIKES detonates.
module button_sequence_controller #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_code,
  output logic [3:0] buttons [0:7],
  output logic       busy,
  output logic       solved,
  output logic       exploded,
  output logic       strike,
  output logic [1:0] strikes
);

  typedef enum logic [2:0] {IDLE, GEN, PLAY, DONE, BOOM} state_t;

  localparam logic [15:0] LFSR_INIT    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [1:0]  STRIKE_LIMIT = 2'(MAX_STRIKES);

  state_t      state, state_next;
  logic [15:0] lfsr;
  logic [2:0]  idx;
  logic        lfsr_fb;
  logic        round_start, gen_write, press_hit, press_miss;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    round_start = 1'b0;
    gen_write   = 1'b0;
    press_hit   = 1'b0;
    press_miss  = 1'b0;
    busy        = 1'b0;
    solved      = 1'b0;
    exploded    = 1'b0;
    case (state)
      IDLE, DONE, BOOM: begin
        solved   = (state == DONE);
        exploded = (state == BOOM);
        if (start) begin
          round_start = 1'b1;
          state_next  = GEN;
        end
      end
      GEN: begin
        busy = 1'b1;
        // Symbols 6 and 7 do not exist, so those LFSR draws are skipped.
        if (lfsr[2:0] < 3'd6) begin
          gen_write = 1'b1;
          if (idx == 3'd7) state_next = PLAY;
        end
      end
      PLAY: begin
        busy = 1'b1;
        if (btn_valid) begin
          if (btn_code == buttons[idx][2:0]) begin
            press_hit = 1'b1;
            if (idx == 3'd7) state_next = DONE;
          end else begin
            press_miss = 1'b1;
            if (strikes + 2'd1 == STRIKE_LIMIT) state_next = BOOM;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_INIT;
      idx     <= 3'd0;
      strike  <= 1'b0;
      strikes <= 2'd0;
      for (int i = 0; i < 8; i++) buttons[i] <= 4'b0000;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr_fb};
      strike <= press_miss;
      if (round_start) begin
        idx     <= 3'd0;
        strikes <= 2'd0;
        for (int i = 0; i < 8; i++) buttons[i] <= 4'b0000;
      end
      // idx wraps 7 -> 0 on the last write/hit, which is the PLAY/DONE starting index.
      if (gen_write) begin
        buttons[idx] <= {1'b0, lfsr[2:0]};
        idx          <= idx + 3'd1;
      end
      if (press_hit) begin
        buttons[idx][3] <= 1'b1;
        idx             <= idx + 3'd1;
      end
      if (press_miss) begin
        idx <= 3'd0;
        if (strikes != STRIKE_LIMIT) strikes <= strikes + 2'd1;
        for (int i = 0; i < 8; i++) buttons[i][3] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_sequence_controller.sv
// Bench for button_sequence_controller: random presses scored against a progress-count model of the game.
module tb_button_sequence_controller;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          MAX_STRIKES = 3;
  localparam int P_IDLE = 0, P_GEN = 1, P_PLAY = 2, P_DONE = 3, P_BOOM = 4;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, btn_valid = 1'b0;
  logic [2:0] btn_code = 3'd0;
  logic [3:0] buttons [0:7];
  logic       busy, solved, exploded, strike;
  logic [1:0] strikes;
  int checks = 0, errors = 0;

  // Game model: slot types, how many slots are matched, how many are generated.
  int          m_phase, m_filled, m_progress, m_strikes, m_gen_cycles;
  bit          m_strike;
  logic [15:0] m_lfsr, m_cur;
  logic [2:0]  m_types [8];

  button_sequence_controller #(.SEED(SEED), .MAX_STRIKES(MAX_STRIKES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_valid(btn_valid), .btn_code(btn_code),
    .buttons(buttons), .busy(busy), .solved(solved), .exploded(exploded),
    .strike(strike), .strikes(strikes)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic logic [3:0] exp_btn(input int i);
    return {1'(i < m_progress), m_types[i]};
  endfunction

  function automatic logic [2:0] wrong_code();
    logic [2:0] c;
    do c = 3'($urandom_range(0, 5)); while (c == m_types[m_progress]);
    return c;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_lfsr = (SEED == 16'h0) ? 16'h0001 : SEED;
      m_filled = 0; m_progress = 0; m_strikes = 0; m_strike = 0; m_gen_cycles = 0;
      foreach (m_types[i]) m_types[i] = 3'd0;
    end else begin
      m_cur = m_lfsr; m_lfsr = lfsr_next(m_cur); m_strike = 0;
      case (m_phase)
        P_IDLE, P_DONE, P_BOOM: if (start) begin
          m_phase = P_GEN; m_filled = 0; m_progress = 0; m_strikes = 0; m_gen_cycles = 0;
          foreach (m_types[i]) m_types[i] = 3'd0;
        end
        P_GEN: begin
          m_gen_cycles++;
          if (m_cur[2:0] < 3'd6) begin
            m_types[m_filled] = m_cur[2:0];
            m_filled++;
            if (m_filled == 8) m_phase = P_PLAY;
          end
        end
        P_PLAY: if (btn_valid) begin
          if (btn_code == m_types[m_progress]) begin
            m_progress++;
            if (m_progress == 8) m_phase = P_DONE;
          end else begin
            m_strike = 1; m_progress = 0;
            if (m_strikes < MAX_STRIKES) m_strikes++;
            if (m_strikes == MAX_STRIKES) m_phase = P_BOOM;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic cycle(input bit v, input logic [2:0] c, input bit s);
    btn_valid = v; btn_code = c; start = s;
    @(negedge clk);
    btn_valid = 1'b0; start = 1'b0;
  endtask

  task automatic new_round(output bit ok);
    cycle(1'b0, 3'd0, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_phase == P_PLAY) begin ok = 1'b1; break; end
      cycle(1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, solved, exploded, strike, strikes} !== 6'b0)
      $display("FAIL reset_flags got busy/solved/exploded/strike/strikes=%b want 000000", {busy, solved, exploded, strike, strikes});
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (buttons[i] !== 4'b0000) begin errors++; $display("FAIL reset_slot%0d got %b want 0000", i, buttons[i]); end
    end
    if ({busy, solved, exploded, strike, strikes} !== 6'b0) errors++;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
      checks++;
      if (busy !== 1'b0 || strike !== 1'b0 || strikes !== 2'd0 || buttons[0] !== 4'b0000) begin
        errors++; $display("FAIL idle_ignore busy=%b strike=%b strikes=%0d slot0=%b want 0/0/0/0000", busy, strike, strikes, buttons[0]);
      end
    end
  endtask

  task automatic test_generation();
    int hold = $urandom_range(1, 4);
    bit ok = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      cycle(1'b0, 3'd0, 1'(cyc < hold));
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL gen_busy cycle %0d got %b want 1", cyc, busy); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (buttons[i] !== exp_btn(i) || buttons[i][2:0] > 3'd5) begin
          errors++; $display("FAIL gen_slot%0d cycle %0d got %b want %b", i, cyc, buttons[i], exp_btn(i));
        end
      end
      if (m_phase == P_PLAY) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || m_gen_cycles < 8) begin errors++; $display("FAIL gen_exit done=%0d gen_cycles=%0d want done=1 cycles>=8", ok, m_gen_cycles); end
  endtask

  task automatic test_solve();
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, 3'd0, 1'b0);
      cycle(1'b1, m_types[m_progress], 1'b0);
      checks++;
      if (buttons[k][3] !== 1'b1) begin errors++; $display("FAIL solve_bit slot%0d got %b want 1", k, buttons[k][3]); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (buttons[i] !== exp_btn(i)) begin errors++; $display("FAIL solve_slot%0d press %0d got %b want %b", i, k, buttons[i], exp_btn(i)); end
      end
    end
    checks++;
    if (solved !== 1'b1 || busy !== 1'b0 || exploded !== 1'b0) begin
      errors++; $display("FAIL solve_flags solved=%b busy=%b exploded=%b want 1/0/0", solved, busy, exploded);
    end
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      checks++;
      if (solved !== 1'b1 || strike !== 1'b0 || buttons[n] !== {1'b1, m_types[n]}) begin
        errors++; $display("FAIL solve_sticky solved=%b strike=%b slot%0d=%b want 1/0/%b", solved, strike, n, buttons[n], {1'b1, m_types[n]});
      end
    end
  endtask

  task automatic test_strike();
    bit ok;
    new_round(ok);
    checks++;
    if (!ok || busy !== 1'b1 || strikes !== 2'd0) begin errors++; $display("FAIL strike_round ok=%0d busy=%b strikes=%0d want 1/1/0", ok, busy, strikes); end
    for (int k = 0; k < 3; k++) cycle(1'b1, m_types[m_progress], 1'b0);
    cycle(1'b1, wrong_code(), 1'b0);
    checks++;
    if (strike !== 1'b1 || strikes !== 2'd1) begin errors++; $display("FAIL strike_pulse strike=%b strikes=%0d want 1/1", strike, strikes); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (buttons[i] !== {1'b0, m_types[i]}) begin errors++; $display("FAIL strike_clear slot%0d got %b want %b", i, buttons[i], {1'b0, m_types[i]}); end
    end
    cycle(1'b0, 3'd0, 1'b0);
    checks++;
    if (strike !== 1'b0) begin errors++; $display("FAIL strike_once got %b want 0", strike); end
    cycle(1'b1, m_types[0], 1'b0);
    checks++;
    if (buttons[0][3] !== 1'b1 || buttons[1][3] !== 1'b0 || strike !== 1'b0 || strikes !== 2'd1) begin
      errors++; $display("FAIL strike_restart slot0=%b slot1=%b strike=%b strikes=%0d want 1/0/0/1", buttons[0][3], buttons[1][3], strike, strikes);
    end
  endtask

  task automatic test_detonation();
    bit ok = 1'b0;
    cycle(1'b1, wrong_code(), 1'b0);
    checks++;
    if (strikes !== 2'd2 || exploded !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL boom_second strikes=%0d exploded=%b busy=%b want 2/0/1", strikes, exploded, busy);
    end
    cycle(1'b1, 3'd7, 1'b0);
    checks++;
    if (strike !== 1'b1 || strikes !== 2'd3 || exploded !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL boom_third strike=%b strikes=%0d exploded=%b busy=%b want 1/3/1/0", strike, strikes, exploded, busy);
    end
    for (int n = 0; n < 4; n++) begin
      cycle(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      checks++;
      if (strike !== 1'b0 || strikes !== 2'd3 || exploded !== 1'b1 || buttons[n] !== {1'b0, m_types[n]}) begin
        errors++; $display("FAIL boom_sticky strike=%b strikes=%0d exploded=%b slot%0d=%b want 0/3/1/%b", strike, strikes, exploded, n, buttons[n], {1'b0, m_types[n]});
      end
    end
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (busy !== 1'b1 || strikes !== 2'd0 || exploded !== 1'b0) begin
      errors++; $display("FAIL boom_restart busy=%b strikes=%0d exploded=%b want 1/0/0", busy, strikes, exploded);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (buttons[i] !== 4'b0000) begin errors++; $display("FAIL boom_clear slot%0d got %b want 0000", i, buttons[i]); end
    end
    for (int n = 0; n < 200; n++) begin
      if (m_phase == P_PLAY) begin ok = 1'b1; break; end
      cycle(1'b0, 3'd0, 1'b0);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL boom_regen timeout got phase %0d want %0d", m_phase, P_PLAY); end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, m_types[0], 1'b1);
    checks++;
    if (buttons[0] !== {1'b1, m_types[0]} || busy !== 1'b1 || strike !== 1'b0) begin
      errors++; $display("FAIL simul_press slot0=%b busy=%b strike=%b want %b/1/0", buttons[0], busy, strike, {1'b1, m_types[0]});
    end
    cycle(1'b0, 3'd0, 1'b1);
    checks++;
    if (buttons[0] !== {1'b1, m_types[0]} || buttons[7] !== {1'b0, m_types[7]}) begin
      errors++; $display("FAIL simul_norestart slot0=%b slot7=%b want %b/%b", buttons[0], buttons[7], {1'b1, m_types[0]}, {1'b0, m_types[7]});
    end
  endtask

  task automatic test_reset_mid_play();
    cycle(1'b1, wrong_code(), 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, m_types[m_progress], 1'b0);
    checks++;
    if (buttons[2][3] !== 1'b1 || strikes !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL prereset slot2=%b strikes=%0d busy=%b want 1/1/1", buttons[2][3], strikes, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || strikes !== 2'd0 || strike !== 1'b0 || solved !== 1'b0 || exploded !== 1'b0) begin
      errors++; $display("FAIL async_reset busy=%b strikes=%0d strike=%b solved=%b exploded=%b want all 0", busy, strikes, strike, solved, exploded);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (buttons[i] !== 4'b0000) begin errors++; $display("FAIL async_reset_slot%0d got %b want 0000", i, buttons[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(1'b1, 3'd0, 1'b0);
    checks++;
    if (busy !== 1'b0 || buttons[0] !== 4'b0000) begin errors++; $display("FAIL post_reset_idle busy=%b slot0=%b want 0/0000", busy, buttons[0]); end
  endtask

  task automatic test_random_rounds();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      new_round(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_round%0d gen timeout", r); end
      for (int n = 0; n < 150 && m_phase == P_PLAY; n++) begin
        int pick = $urandom_range(0, 99);
        if (pick < 30)      cycle(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0));
        else if (pick < 85) cycle(1'b1, m_types[m_progress], 1'($urandom_range(0, 9) == 0));
        else                cycle(1'b1, (pick < 92) ? wrong_code() : 3'($urandom_range(6, 7)), 1'b0);
        checks++;
        if (busy !== 1'(m_phase == P_GEN || m_phase == P_PLAY) || solved !== 1'(m_phase == P_DONE) ||
            exploded !== 1'(m_phase == P_BOOM) || strike !== m_strike || strikes !== 2'(m_strikes)) begin
          errors++; $display("FAIL rand_flags round %0d busy=%b solved=%b exploded=%b strike=%b strikes=%0d want phase %0d strike=%0d strikes=%0d",
                             r, busy, solved, exploded, strike, strikes, m_phase, m_strike, m_strikes);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (buttons[i] !== exp_btn(i)) begin errors++; $display("FAIL rand_slot%0d round %0d got %b want %b", i, r, buttons[i], exp_btn(i)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_generation();
    test_solve();
    test_strike();
    test_detonation();
    test_simultaneous();
    test_reset_mid_play();
    test_random_rounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_sequence_controller.md
BUTTON_SEQUENCE_CONTROLLER -- requirements
Module: button_sequence_controller

Interface
REQ-001 Parameter SEED, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
REQ-002 Parameter MAX_STRIKES, default 3: strike count (1..3) that detonates the bomb.
REQ-003 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level sampled each cycle; begins a new round.
REQ-007 btn_valid  input  1  one-cycle pulse: player pressed a button.
REQ-008 btn_code  input  3  pressed symbol: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN, 4 A, 5 B.
REQ-009 buttons  output  4 x [0:7]  per slot: [2:0] symbol type, [3] colour (1 = red = matched, 0 = blue = pending); feeds graphics_controller directly.
REQ-010 busy  output  1  high in GEN and PLAY.
REQ-011 solved  output  1  high in DONE.
REQ-012 exploded  output  1  high in BOOM.
REQ-013 strike  output  1  one-cycle pulse per wrong press.
REQ-014 strikes  output  2  strikes taken this round.

Function
REQ-015 States: IDLE, GEN, PLAY, DONE, BOOM.
REQ-016 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left with feedback into bit 0, advances every clock in every state.
REQ-017 IDLE: start=1 -> GEN next cycle; slot index idx := 0; strikes := 0; all buttons[i] := 4'b0000.
REQ-018 GEN: each cycle, if lfsr[2:0] < 6, write {1'b0, lfsr[2:0]} to buttons[idx], then idx++. Otherwise write nothing that cycle (values 6 and 7 are rejected).
REQ-019 GEN exit: the write to slot 7 -> PLAY next cycle with idx := 0; minimum GEN length 8 cycles.
REQ-020 PLAY correct press: btn_valid=1 and btn_code == buttons[idx][2:0] -> buttons[idx][3] := 1 and idx++. If idx was 7, go to DONE.
REQ-021 PLAY wrong press: btn_valid=1 and code mismatch ->
  - strike=1 for exactly that next cycle;
  - strikes++;
  - all buttons[i][3] := 0, idx := 0, symbol types unchanged.
REQ-022 Strike limit: a wrong press that makes strikes == MAX_STRIKES -> BOOM (strike still pulses, strikes saturates at MAX_STRIKES).
REQ-023 btn_valid outside PLAY is ignored, with no state change and no strike.
REQ-024 btn_code values 6 and 7 in PLAY count as a mismatch.
REQ-025 start in GEN or PLAY is ignored; start together with btn_valid in PLAY: the press is processed, start is ignored.
REQ-026 DONE and BOOM are sticky; buttons hold their value. start=1 -> GEN next cycle with idx := 0, strikes := 0, and all slots cleared to 4'b0000.
REQ-027 Press effects are visible on outputs one clock after the btn_valid edge; no combinational path from inputs to outputs.
REQ-028 Outputs are decoded from state: busy, solved and exploded are registered or state-decoded only.

Reset
REQ-029 On rst_n=0 (asynchronous, any state, including mid-GEN or mid-PLAY), the following take effect immediately:
  - state=IDLE, idx=0, lfsr=SEED (or 1 if SEED is 0);
  - all buttons=4'b0000;
  - busy=0, solved=0, exploded=0, strike=0, strikes=0.
REQ-030 After release, the block stays in IDLE until start is sampled high; rst_n release is synchronous to clk in the surrounding design.

Verification
REQ-031 Reset: assert rst_n=0 mid-PLAY after 3 correct presses -> all buttons 0, busy=0, strikes=0 within the same cycle, with no clock edge needed.
REQ-032 Generation: SEED default, pulse start -> compare slot contents against a reference LFSR model. No slot holds a type of 6 or 7; busy=1 throughout; PLAY entered the cycle after the slot-7 write.
REQ-033 Solve: 8 presses matching buttons[0..7][2:0] -> bit3 of slots 0..7 set in order, solved=1 after the 8th press, busy=0; further presses ignored.
REQ-034 Strike/reset-progress: 3 correct presses then a wrong code -> strike pulses once, strikes=1, all bit3=0, and the next press is checked against slot 0.
REQ-035 Detonation: MAX_STRIKES=3, three wrong presses -> exploded=1 after the third, strikes=3, further btn_valid ignored; start -> GEN with strikes=0.
REQ-036 Simultaneous events: start and correct btn_valid in the same cycle during PLAY -> the press is accepted and the round is not restarted; btn_code=7 -> counted as a strike.
